// File: rtl/booth_mult_mac_seq.sv
// booth_mult_mac_seq
//   Feeds signed operand pairs to a radix-2 Booth multiplier one at a time,
//   sums the products into a dot-product accumulator and hands the total
//   out on a valid/ready result port.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   i_in_valid/o_in_ready            operand pair handshake
//   i_in_a, i_in_b, i_in_last        signed operands, end-of-accumulation flag
//   o_mul_a, o_mul_b, o_mul_start    operands and start pulse to the multiplier
//   i_mul_product, i_mul_err,
//   i_mul_ready                      product, error and ready from the multiplier
//   o_acc_valid/i_acc_ready          result handshake
//   o_acc_data, o_acc_count, o_acc_err  signed sum, term count, sticky error
//
// state   | meaning
// IDLE    | ready for the next operand pair
// ISSUE   | mul_start pulse to the multiplier
// WAIT_LO | waiting for the multiplier to drop a stale ready
// WAIT_HI | waiting for the new product
// ACCUM   | add product, bump count, merge error
// OUT     | result presented, waiting for acc_ready
module booth_mult_mac_seq #(
   parameter int L_WORD  = 4,
   parameter int N_TERMS = 8,
   parameter int TIMEOUT = 64,
   localparam int ACC_W  = 2*L_WORD + $clog2(N_TERMS),
   localparam int CNT_W  = $clog2(N_TERMS+1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   input  logic [L_WORD-1:0]   i_in_a,
   input  logic [L_WORD-1:0]   i_in_b,
   input  logic                i_in_last,
   output logic [L_WORD-1:0]   o_mul_a,
   output logic [L_WORD-1:0]   o_mul_b,
   output logic                o_mul_start,
   input  logic [2*L_WORD-1:0] i_mul_product,
   input  logic                i_mul_err,
   input  logic                i_mul_ready,
   output logic                o_acc_valid,
   input  logic                i_acc_ready,
   output logic [ACC_W-1:0]    o_acc_data,
   output logic [CNT_W-1:0]    o_acc_count,
   output logic                o_acc_err
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT_LO = 3'd2,
      WAIT_HI = 3'd3,
      ACCUM   = 3'd4,
      OUT     = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_in_ready;
   logic                r_mul_start;
   logic                r_acc_valid;
   logic [L_WORD-1:0]   r_mul_a;
   logic [L_WORD-1:0]   r_mul_b;
   logic                r_last;
   logic [2*L_WORD-1:0] r_prod;
   logic                r_perr;
   logic [TO_W-1:0]     r_to_cnt;
   logic [ACC_W-1:0]    r_acc_data;
   logic [CNT_W-1:0]    r_acc_count;
   logic                r_acc_err;

   logic                w_accept;
   logic                w_timeout;
   logic                w_capture;
   logic                w_abort;
   logic [CNT_W-1:0]    w_cnt_inc;
   logic [ACC_W-1:0]    w_prod_sx;

   assign w_accept  = i_in_valid && r_in_ready;
   assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT-1));
   assign w_capture = (r_state == WAIT_HI) && i_mul_ready;
   // A timeout only counts when the wait state would not have exited anyway.
   assign w_abort   = w_timeout &&
                      (((r_state == WAIT_LO) && i_mul_ready) ||
                       ((r_state == WAIT_HI) && !i_mul_ready));
   assign w_cnt_inc = r_acc_count + 1'b1;
   assign w_prod_sx = {{(ACC_W-2*L_WORD){r_prod[2*L_WORD-1]}}, r_prod};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = WAIT_LO;
         WAIT_LO: if (!i_mul_ready || w_abort) w_state_nxt = i_mul_ready ? ACCUM : WAIT_HI;
         WAIT_HI: if (i_mul_ready || w_abort) w_state_nxt = ACCUM;
         ACCUM:   w_state_nxt = (r_last || (w_cnt_inc == CNT_W'(N_TERMS))) ? OUT : IDLE;
         OUT:     if (i_acc_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b0;
         r_mul_start <= 1'b0;
         r_acc_valid <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_last      <= 1'b0;
         r_prod      <= '0;
         r_perr      <= 1'b0;
         r_to_cnt    <= '0;
         r_acc_data  <= '0;
         r_acc_count <= '0;
         r_acc_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         // Handshake/strobe outputs are registered from the next state so
         // they line up exactly with the state they belong to.
         r_in_ready  <= (w_state_nxt == IDLE);
         r_mul_start <= (w_state_nxt == ISSUE);
         r_acc_valid <= (w_state_nxt == OUT);

         if (w_accept) begin
            r_mul_a <= i_in_a;
            r_mul_b <= i_in_b;
            r_last  <= i_in_last;
         end

         if ((r_state == WAIT_LO) || (r_state == WAIT_HI))
            r_to_cnt <= r_to_cnt + 1'b1;
         else
            r_to_cnt <= '0;

         if (w_capture) begin
            r_prod <= i_mul_product;
            r_perr <= i_mul_err;
         end else if (w_abort) begin
            r_prod <= '0;
            r_perr <= 1'b1;
         end

         if (r_state == ACCUM) begin
            r_acc_data  <= r_acc_data + w_prod_sx;
            r_acc_count <= w_cnt_inc;
            r_acc_err   <= r_acc_err | r_perr;
         end else if ((r_state == OUT) && i_acc_ready) begin
            r_acc_data  <= '0;
            r_acc_count <= '0;
            r_acc_err   <= 1'b0;
         end
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_mul_a     = r_mul_a;
   assign o_mul_b     = r_mul_b;
   assign o_mul_start = r_mul_start;
   assign o_acc_valid = r_acc_valid;
   assign o_acc_data  = r_acc_data;
   assign o_acc_count = r_acc_count;
   assign o_acc_err   = r_acc_err;

endmodule

// File: tb/tb_booth_mult_mac_seq.sv
module tb_booth_mult_mac_seq;

   localparam int L_WORD = 4;
   localparam int ACC_W  = 11;
   localparam int CNT_W  = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [L_WORD-1:0]   in_a = '0;
   logic [L_WORD-1:0]   in_b = '0;
   logic                in_last = 1'b0;
   logic [L_WORD-1:0]   mul_a;
   logic [L_WORD-1:0]   mul_b;
   logic                mul_start;
   logic [2*L_WORD-1:0] mul_product = '0;
   logic                mul_err = 1'b0;
   logic                mul_ready = 1'b0;
   logic                acc_valid;
   logic                acc_ready = 1'b0;
   logic [ACC_W-1:0]    acc_data;
   logic [CNT_W-1:0]    acc_count;
   logic                acc_err;

   always #5 clk = ~clk;

   booth_mult_mac_seq #(.L_WORD(4), .N_TERMS(8), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_a(in_a), .i_in_b(in_b), .i_in_last(in_last),
      .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_start(mul_start),
      .i_mul_product(mul_product), .i_mul_err(mul_err), .i_mul_ready(mul_ready),
      .o_acc_valid(acc_valid), .i_acc_ready(acc_ready),
      .o_acc_data(acc_data), .o_acc_count(acc_count), .o_acc_err(acc_err)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Multiplier model: keeps ready high (stale) for one cycle after start,
   // then drops it, and raises it again with the product after lat cycles.
   // stuck=1 never drops ready, which forces the controller's timeout.
   int               lat = 3;
   bit               stuck = 1'b0;
   bit               err_arm = 1'b0;
   bit               cur_err = 1'b0;
   bit               busy = 1'b0;
   bit               prev_start = 1'b0;
   int               mcnt = 0;
   int               n_starts = 0;
   logic [L_WORD-1:0] seen_a = '0;
   logic [L_WORD-1:0] seen_b = '0;
   logic signed [7:0] sa, sb;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy = 1'b0;
         prev_start = 1'b0;
         if (!stuck) mul_ready = 1'b0;
      end else begin
         if (mul_start) begin
            chk("start_pulse_width", 32'(prev_start), 32'd0);
            n_starts++;
            busy = 1'b1;
            mcnt = lat;
            seen_a = mul_a;
            seen_b = mul_b;
            sa = $signed(mul_a);
            sb = $signed(mul_b);
            cur_err = err_arm;
         end else if (busy) begin
            if (!stuck) mul_ready = 1'b0;
            mcnt--;
            if (mcnt <= 0) begin
               mul_product = sa * sb;
               mul_err = cur_err;
               mul_ready = 1'b1;
               busy = 1'b0;
            end
         end
         prev_start = mul_start;
      end
   end

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) chk("send_wait_in_ready", 32'd0, 32'd1);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_last = last;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      @(negedge clk);
      while (!acc_valid && !in_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) chk("wait_done_bound", 32'd0, 32'd1);
   endtask

   task automatic handshake();
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      chk("hs_valid_drop", 32'(acc_valid), 32'd0);
      chk("hs_data_clear", 32'(acc_data), 32'd0);
      chk("hs_count_clear", 32'(acc_count), 32'd0);
      chk("hs_err_clear", 32'(acc_err), 32'd0);
   endtask

   task automatic expect_result(input string name, input logic [10:0] d,
                                input logic [3:0] c, input logic e);
      chk({name, "_valid"}, 32'(acc_valid), 32'd1);
      chk({name, "_data"}, 32'(acc_data), 32'(d));
      chk({name, "_count"}, 32'(acc_count), 32'(c));
      chk({name, "_err"}, 32'(acc_err), 32'(e));
   endtask

   typedef struct {
      logic [3:0]  a;
      logic [3:0]  b;
      logic        last;
      logic        err;
      logic        chk_out;
      logic [10:0] data;
      logic [3:0]  cnt;
      logic        aerr;
   } vec_t;

   vec_t vt[16];

   initial begin
      int s0;
      // single term: 3 * -2 = -6
      vt[0]  = '{4'h3, 4'hE, 1, 0, 1, 11'h7FA, 4'd1, 0};
      // eight terms of -8 * -8 = 64, closed by the term limit
      for (int i = 1; i <= 8; i++)
         vt[i] = '{4'h8, 4'h8, 0, 0, (i == 8), 11'h200, 4'd8, 0};
      // error on the middle term: 5 + 4 - 3 = 6
      vt[9]  = '{4'h5, 4'h1, 0, 0, 0, 11'h000, 4'd0, 0};
      vt[10] = '{4'h2, 4'h2, 0, 1, 0, 11'h000, 4'd0, 0};
      vt[11] = '{4'hF, 4'h3, 1, 0, 1, 11'h006, 4'd3, 1};
      // clean result after the error one: 49
      vt[12] = '{4'h7, 4'h7, 1, 0, 1, 11'h031, 4'd1, 0};
      // -56 - 56 + 1 = -111
      vt[13] = '{4'h8, 4'h7, 0, 0, 0, 11'h000, 4'd0, 0};
      vt[14] = '{4'h7, 4'h8, 0, 0, 0, 11'h000, 4'd0, 0};
      vt[15] = '{4'hF, 4'hF, 1, 0, 1, 11'h791, 4'd3, 0};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mul_start", 32'(mul_start), 32'd0);
      chk("rst_mul_a", 32'(mul_a), 32'd0);
      chk("rst_acc_valid", 32'(acc_valid), 32'd0);
      chk("rst_acc_data", 32'(acc_data), 32'd0);
      chk("rst_acc_count", 32'(acc_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_in_ready", 32'(in_ready), 32'd1);

      // table-driven vectors
      for (int i = 0; i < 16; i++) begin
         s0 = n_starts;
         err_arm = vt[i].err;
         send(vt[i].a, vt[i].b, vt[i].last);
         wait_done();
         err_arm = 1'b0;
         chk($sformatf("v%0d_starts", i), 32'(n_starts - s0), 32'd1);
         chk($sformatf("v%0d_mul_a", i), 32'(seen_a), 32'(vt[i].a));
         chk($sformatf("v%0d_mul_b", i), 32'(seen_b), 32'(vt[i].b));
         if (vt[i].chk_out) begin
            expect_result($sformatf("v%0d", i), vt[i].data, vt[i].cnt, vt[i].aerr);
            handshake();
         end else begin
            chk($sformatf("v%0d_no_valid", i), 32'(acc_valid), 32'd0);
         end
      end

      // backpressure: result held while acc_ready low, inputs ignored
      send(4'h1, 4'h1, 1'b1);
      wait_done();
      expect_result("bp", 11'h001, 4'd1, 1'b0);
      s0 = n_starts;
      in_valid = 1'b1;
      in_a = 4'h7;
      in_b = 4'h7;
      in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid_held", 32'(acc_valid), 32'd1);
         chk("bp_data_stable", 32'(acc_data), 32'h001);
         chk("bp_count_stable", 32'(acc_count), 32'd1);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      chk("bp_no_issue", 32'(n_starts - s0), 32'd0);
      handshake();
      send(4'h2, 4'h3, 1'b1);
      wait_done();
      expect_result("bp_next", 11'h006, 4'd1, 1'b0);
      handshake();

      // reset in the middle of WAIT_HI discards the partial sum
      send(4'h2, 4'h2, 1'b0);
      wait_done();
      lat = 10;
      send(4'h1, 4'h1, 1'b0);
      repeat (6) @(negedge clk);
      chk("mid_in_ready_busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
         chk("mid_rst_mul_start", 32'(mul_start), 32'd0);
         chk("mid_rst_mul_b", 32'(mul_b), 32'd0);
         chk("mid_rst_acc_data", 32'(acc_data), 32'd0);
         chk("mid_rst_acc_count", 32'(acc_count), 32'd0);
         chk("mid_rst_acc_valid", 32'(acc_valid), 32'd0);
      end
      rst_n = 1'b1;
      lat = 3;
      @(negedge clk);
      chk("mid_release_in_ready", 32'(in_ready), 32'd1);
      chk("mid_release_acc_valid", 32'(acc_valid), 32'd0);
      send(4'h3, 4'hE, 1'b1);
      wait_done();
      expect_result("after_rst", 11'h7FA, 4'd1, 1'b0);
      handshake();

      // timeout: ready never drops, term counted as 0 with error
      stuck = 1'b1;
      mul_ready = 1'b1;
      send(4'h3, 4'h3, 1'b1);
      wait_done();
      expect_result("timeout", 11'h000, 4'd1, 1'b1);
      handshake();
      stuck = 1'b0;
      send(4'h2, 4'h2, 1'b1);
      wait_done();
      expect_result("post_timeout", 11'h004, 4'd1, 1'b0);
      handshake();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/booth_mult_mac_seq.md
Name: booth_mult_mac_seq

Overview:
Sequencer and accumulator wrapped around the radix-2 Booth multiplier (Mbooth_mult_radix2). Accepts signed operand pairs on a valid/ready stream and issues each pair to the multiplier through its start/ready interface. Sign-extends and sums the products into a dot-product accumulator, then presents the total on a valid/ready result port. Sits directly upstream (operand feed) and downstream (product consumer) of the multiplier.

Parameters:
L_WORD, 4, operand width in bits, two's complement; must match the multiplier.
N_TERMS, 8, maximum products per accumulation; must be >= 2.
TIMEOUT, 64, cycles to wait for the multiplier before aborting one term.
ACC_W, 2*L_WORD+$clog2(N_TERMS), derived localparam, accumulator width.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept a pair
in_a  input  L_WORD  signed multiplicand
in_b  input  L_WORD  signed multiplier
in_last  input  1  pair closes the current accumulation
mul_a  output  L_WORD  operand to multiplier word1
mul_b  output  L_WORD  operand to multiplier word2
mul_start  output  1  one-cycle start pulse
mul_product  input  2*L_WORD  signed product from multiplier
mul_err  input  1  multiplier error flag
mul_ready  input  1  multiplier product valid
acc_valid  output  1  accumulated result valid
acc_ready  input  1  result accepted
acc_data  output  ACC_W  signed accumulated sum
acc_count  output  $clog2(N_TERMS+1)  number of terms in acc_data
acc_err  output  1  sticky error (mul_err or timeout) for this result

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready=0 during reset. mul_start=0, mul_a=0, mul_b=0, acc_valid=0, acc_data=0, acc_count=0, acc_err=0. Timeout counter=0. All outputs are registered.
- Reset asserted mid-operation aborts immediately. Any partial sum is discarded and no result is emitted.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_a->mul_a, in_b->mul_b and in_last, then go to ISSUE. mul_a/mul_b hold until the next capture.
- ISSUE: mul_start=1 for exactly one cycle (one cycle after the accept edge), then go to WAIT_LO.
- WAIT_LO: wait for mul_ready==0 (the multiplier drops ready after start), then go to WAIT_HI. This rejects a stale ready left over from the previous product.
- WAIT_HI: on mul_ready==1, capture mul_product and mul_err, then go to ACCUM.
- Timeout: the counter runs during WAIT_LO and WAIT_HI. When it reaches TIMEOUT-1 with no exit, the term is taken as product 0 with error=1, and the state goes to ACCUM.
- ACCUM (one cycle):
  - acc_data += sign-extended product (bit 2*L_WORD-1 replicated to ACC_W).
  - acc_count++.
  - acc_err |= captured error.
  - If latched in_last==1 or the new acc_count==N_TERMS, go to OUT; else go to IDLE.
- OUT: acc_valid=1, in_ready=0, and acc_data/acc_count/acc_err are stable.
  - On acc_valid&&acc_ready, clear acc_data, acc_count and acc_err to 0, deassert acc_valid and go to IDLE.
  - acc_ready held low stalls indefinitely.
- ACC_W never overflows. The worst case is N_TERMS x (-2^(L-1))^2 = N_TERMS x 2^(2L-2), which is within signed range.
- mul_start is never asserted outside ISSUE. Only one multiplication is outstanding at a time.
- in_ready is asserted only in IDLE. Throughput is one pair per (multiplier latency + 5) cycles at minimum.
- An ignored mul_ready pulse (in IDLE or OUT) has no effect.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-WAIT_HI, then release -> all outputs 0, state IDLE, in_ready=1 one cycle after release, no acc_valid.
- Single term: a=4'h3, b=4'hE, last=1 -> exactly one mul_start pulse, then acc_valid with acc_data=-6 (11'h7FA), acc_count=1, acc_err=0.
- Full accumulation: 8 pairs of a=4'h8, b=4'h8, last=0 -> acc_valid only after the 8th term, acc_data=512 (11'h200), acc_count=8.
- Backpressure: acc_ready=0 for 10 cycles while acc_valid=1 -> acc_data/acc_count stable, in_ready=0 and in_valid ignored. Then acc_ready=1 -> single handshake, accumulator cleared, next result counts from 0.
- Error propagation: mul_err=1 on term 2 of a 3-term sequence (5x1, 2x2, -1x3) -> acc_data=6, acc_count=3, acc_err=1. The next result has acc_err=0.
- Timeout: model holds mul_ready=1 permanently after start -> after TIMEOUT cycles the term is counted as 0, acc_err=1, and the state machine returns to IDLE without hanging.
